register_set: RTL and testbench



---
 rtl/register_set.sv | 39 +++
 tb/tb_register_set.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/register_set.sv
// register_set: 16 x 32 general-purpose register file.
// Two combinational read ports, one synchronous write port.
module register_set #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] readAddress1,
  input  logic [ADDR_WIDTH-1:0] readAddress2,
  input  logic [ADDR_WIDTH-1:0] writeAddress,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // Reset clears all entries and drops any same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (writeEnable) begin
      regs[writeAddress] <= writeData;
    end
  end

  // Reads see stored state only; a pending write is not forwarded.
  always_comb begin
    readData1 = regs[readAddress1];
    readData2 = regs[readAddress2];
  end

endmodule

// File: tb/tb_register_set.sv
// tb_register_set: directed test plan plus random traffic,
// checked against an array model of the register file.
module tb_register_set;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        writeEnable = 1'b0;
  logic [3:0]  readAddress1 = '0;
  logic [3:0]  readAddress2 = '0;
  logic [3:0]  writeAddress = '0;
  logic [31:0] writeData = '0;
  logic [31:0] readData1;
  logic [31:0] readData2;

  int n_tests = 0;
  int n_fail = 0;

  logic [31:0] mdl [16];

  register_set dut (
    .clk(clk),
    .reset(reset),
    .writeEnable(writeEnable),
    .readAddress1(readAddress1),
    .readAddress2(readAddress2),
    .writeAddress(writeAddress),
    .writeData(writeData),
    .readData1(readData1),
    .readData2(readData2)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge; the model applies what the inputs requested.
  task automatic tick();
    logic        r;
    logic        w;
    logic [3:0]  wa;
    logic [31:0] wd;
    r  = reset;
    w  = writeEnable;
    wa = writeAddress;
    wd = writeData;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    end else if (w) begin
      mdl[wa] = wd;
    end
    #1;
  endtask

  task automatic wr(logic [3:0] a, logic [31:0] d);
    writeAddress = a;
    writeData = d;
    writeEnable = 1'b1;
    tick();
    writeEnable = 1'b0;
  endtask

  task automatic rd(string tag, logic [3:0] a1, logic [3:0] a2);
    readAddress1 = a1;
    readAddress2 = a2;
    #1;
    check({tag, "_p1"}, readData1, mdl[a1]);
    check({tag, "_p2"}, readData2, mdl[a2]);
  endtask

  task automatic sweep(string tag);
    for (int i = 0; i < 16; i++) begin
      rd(tag, 4'(i), 4'(15 - i));
      rd(tag, 4'(i), 4'(i));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = 'x;

    // arbitrary prior contents, then reset
    for (int i = 0; i < 8; i++) wr(4'($urandom), $urandom);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      readAddress1 = 4'(i);
      readAddress2 = 4'(15 - i);
      #1;
      check("rst_p1", readData1, 32'h0);
      check("rst_p2", readData2, 32'h0);
    end

    // reg 0 and reg 1
    wr(4'd0, 32'b1101);
    readAddress1 = 4'd0;
    readAddress2 = 4'd1;
    #1;
    check("r0_p1", readData1, 32'hD);
    check("r0_p2", readData2, 32'h0);
    wr(4'd1, 32'b1010);
    readAddress1 = 4'd1;
    readAddress2 = 4'd0;
    #1;
    check("r1_p1", readData1, 32'hA);
    check("r1_p2", readData2, 32'hD);

    // no forwarding: old value before edge, new after
    tick();
    writeAddress = 4'd2;
    writeData = 32'hFFFF_FFFF;
    writeEnable = 1'b1;
    readAddress1 = 4'd2;
    #1;
    check("nofwd_pre", readData1, 32'h0);
    tick();
    writeEnable = 1'b0;
    check("nofwd_post", readData1, 32'hFFFF_FFFF);

    // writeEnable low: reg 2 holds
    writeData = 32'h0BAD_0BAD;
    tick();
    tick();
    check("hold", readData1, 32'hFFFF_FFFF);

    // reset beats a simultaneous write
    reset = 1'b1;
    writeEnable = 1'b1;
    writeAddress = 4'd5;
    writeData = 32'h1234_5678;
    tick();
    reset = 1'b0;
    writeEnable = 1'b0;
    rd("rstpri_r5", 4'd5, 4'd0);
    for (int i = 0; i < 16; i++) begin
      readAddress1 = 4'(i);
      #1;
      check("rstpri_all", readData1, 32'h0);
    end

    // back-to-back full sweep
    writeEnable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      writeAddress = 4'(i);
      writeData = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    writeEnable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      readAddress1 = 4'(i);
      readAddress2 = 4'(i);
      #1;
      check("full_p1", readData1, 32'hA5A5_0000 + 32'(i));
      check("full_p2", readData2, 32'hA5A5_0000 + 32'(i));
    end
    sweep("full_model");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [3:0] wa;
      reset = ($urandom_range(0, 31) == 0);
      writeEnable = 1'($urandom);
      wa = 4'($urandom);
      writeAddress = wa;
      writeData = $urandom;
      rd("rnd_pre", 4'($urandom), wa);
      tick();
      reset = 1'b0;
      writeEnable = 1'b0;
      rd("rnd_post", wa, 4'($urandom));
    end
    sweep("rnd_final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
